// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file and its scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned NREGS_DEFAULT = 32;
  localparam int unsigned ZERO_REG      = 0;

  typedef logic [4:0] reg_addr_t;

endpackage

// File: rtl/regfile_entry.sv
// One architectural register: data flop plus busy (pending writeback) flop.
module regfile_entry
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_hit,
  input  logic [XLEN-1:0] wr_data,
  input  logic            claim_hit,
  input  logic            flush,
  output logic [XLEN-1:0] data,
  output logic            busy
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (wr_hit) begin
      data <= wr_data;
    end
  end

  // A younger claim outranks the release of an older writeback; flush outranks both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else if (flush) begin
      busy <= 1'b0;
    end else if (claim_hit) begin
      busy <= 1'b1;
    end else if (wr_hit) begin
      busy <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with optional write bypass and busy scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned NREGS  = NREGS_DEFAULT,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_ena,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  claim_ena,
  input  logic [AW-1:0]         claim_addr,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy_vec
);

  logic [NREGS-1:0][XLEN-1:0] entry_data;
  logic [NREGS-1:0]           entry_busy;
  logic                       wr_live;
  logic                       claim_live;

  assign wr_live    = wr_ena    && (wr_addr    != AW'(ZERO_REG));
  assign claim_live = claim_ena && (claim_addr != AW'(ZERO_REG));

  assign entry_data[0] = '0;
  assign entry_busy[0] = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_entry
    regfile_entry #(.XLEN(XLEN)) u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_hit    (wr_live && (wr_addr == AW'(i))),
      .wr_data   (wr_data),
      .claim_hit (claim_live && (claim_addr == AW'(i))),
      .flush     (flush),
      .data      (entry_data[i]),
      .busy      (entry_busy[i])
    );
  end

  // Bypass is gated by rst_n so every port reads 0 while reset is held.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          bypass_hit;

    assign addr       = rd_addr[k*AW +: AW];
    assign bypass_hit = (BYPASS != 0) && rst_n && wr_live && (wr_addr == addr);
    assign rd_data[k*XLEN +: XLEN] = bypass_hit ? wr_data : entry_data[addr];
    assign rd_busy[k] = bypass_hit ? 1'b0 : entry_busy[addr];
  end

  assign busy_vec = entry_busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench: a bypassing 3-port build and a non-bypassing 2-port build share stimulus against one register model.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        claim_ena;
  logic [4:0]  claim_addr;
  logic        flush;
  logic [14:0] rd_addr_a;
  logic [95:0] rd_data_a;
  logic [2:0]  rd_busy_a;
  logic [31:0] busy_vec_a;
  logic [9:0]  rd_addr_b;
  logic [63:0] rd_data_b;
  logic [1:0]  rd_busy_b;
  logic [31:0] busy_vec_b;

  logic [31:0] m_reg [32];
  logic [31:0] m_busy;
  int          n_checks = 0;
  int          n_fail   = 0;

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(3), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .claim_ena(claim_ena), .claim_addr(claim_addr), .flush(flush), .busy_vec(busy_vec_a)
  );

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .claim_ena(claim_ena), .claim_addr(claim_addr), .flush(flush), .busy_vec(busy_vec_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_busy = '0;
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (!rst_n) return '0;
    if (byp && wr_ena && wr_addr == a && a != 5'd0) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (!rst_n) return 1'b0;
    if (byp && wr_ena && wr_addr == a && a != 5'd0) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check_outputs();
    logic [4:0] a;
    for (int k = 0; k < 3; k++) begin
      a = rd_addr_a[k*5 +: 5];
      check($sformatf("a_data%0d_x%0d", k, a), 64'(rd_data_a[k*32 +: 32]), 64'(exp_data(a, 1'b1)));
      check($sformatf("a_busy%0d_x%0d", k, a), 64'(rd_busy_a[k]), 64'(exp_busy(a, 1'b1)));
    end
    for (int k = 0; k < 2; k++) begin
      a = rd_addr_b[k*5 +: 5];
      check($sformatf("b_data%0d_x%0d", k, a), 64'(rd_data_b[k*32 +: 32]), 64'(exp_data(a, 1'b0)));
      check($sformatf("b_busy%0d_x%0d", k, a), 64'(rd_busy_b[k]), 64'(exp_busy(a, 1'b0)));
    end
    check("a_busy_vec", 64'(busy_vec_a), 64'(m_busy));
    check("b_busy_vec", 64'(busy_vec_b), 64'(m_busy));
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    rd_addr_a = {a2, a1, a0};
    rd_addr_b = {a1, a0};
  endtask

  task automatic idle();
    wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
    claim_ena = 1'b0; claim_addr = '0; flush = 1'b0;
  endtask

  task automatic settle();
    #2;
    check_outputs();
  endtask

  // Architectural rules applied in order: write+release, then claim, then flush.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      if (wr_ena && wr_addr != 5'd0) begin
        m_reg[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (claim_ena && claim_addr != 5'd0) m_busy[claim_addr] = 1'b1;
      if (flush) m_busy = '0;
    end
    #1;
  endtask

  task automatic sweep();
    idle();
    for (int r = 0; r < 32; r += 3) begin
      set_rd(5'(r), 5'((r + 1) % 32), 5'((r + 2) % 32));
      settle();
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    model_clear();
    idle();
    set_rd(5'd1, 5'd2, 5'd3);
    settle();
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    tick();

    // Write x7 with all three ports reading it.
    wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678;
    set_rd(5'd7, 5'd7, 5'd7);
    settle();
    check("x7_byp_p0", 64'(rd_data_a[31:0]), 64'h1234_5678);
    check("x7_byp_p2", 64'(rd_data_a[95:64]), 64'h1234_5678);
    check("x7_nobyp_old", 64'(rd_data_b[31:0]), 64'h0);
    tick();
    idle();
    settle();
    check("x7_persist_a", 64'(rd_data_a[63:32]), 64'h1234_5678);
    check("x7_persist_b", 64'(rd_data_b[31:0]), 64'h1234_5678);
    tick();

    // Zero register write and claim.
    wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    claim_ena = 1'b1; claim_addr = 5'd0;
    set_rd(5'd0, 5'd7, 5'd0);
    settle();
    check("x0_byp_read", 64'(rd_data_a[31:0]), 64'h0);
    tick();
    idle();
    settle();
    check("x0_busy", 64'(busy_vec_a[0]), 64'h0);
    check("x0_read", 64'(rd_data_b[31:0]), 64'h0);
    sweep();

    // Scoreboard claim then release.
    claim_ena = 1'b1; claim_addr = 5'd10;
    set_rd(5'd10, 5'd10, 5'd1);
    settle();
    check("x10_claim_cycle", 64'(rd_busy_a[0]), 64'h0);
    tick();
    idle();
    settle();
    check("x10_busy", 64'(rd_busy_a[0]), 64'h1);
    check("x10_busy_vec", 64'(busy_vec_a[10]), 64'h1);
    wr_ena = 1'b1; wr_addr = 5'd10; wr_data = 32'd42;
    settle();
    check("x10_release_byp", 64'(rd_busy_a[0]), 64'h0);
    check("x10_release_nobyp", 64'(rd_busy_b[0]), 64'h1);
    tick();
    idle();
    settle();
    check("x10_busy_vec_clr", 64'(busy_vec_a[10]), 64'h0);
    tick();

    // Claim and write of the same register in one cycle.
    wr_ena = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_ABCD;
    claim_ena = 1'b1; claim_addr = 5'd12;
    set_rd(5'd12, 5'd12, 5'd12);
    settle();
    tick();
    idle();
    settle();
    check("x12_busy", 64'(busy_vec_a[12]), 64'h1);
    check("x12_data", 64'(rd_data_a[31:0]), 64'h0000_ABCD);

    // Flush together with a claim.
    flush = 1'b1; claim_ena = 1'b1; claim_addr = 5'd3;
    settle();
    tick();
    idle();
    settle();
    check("flush_busy_vec", 64'(busy_vec_a), 64'h0);
    tick();

    // Non-bypassed write visibility and busy.
    claim_ena = 1'b1; claim_addr = 5'd4;
    tick();
    idle();
    wr_ena = 1'b1; wr_addr = 5'd4; wr_data = 32'd9;
    set_rd(5'd4, 5'd4, 5'd4);
    settle();
    check("x4_nobyp_old", 64'(rd_data_b[31:0]), 64'h0);
    check("x4_nobyp_busy", 64'(rd_busy_b[0]), 64'h1);
    tick();
    idle();
    settle();
    check("x4_nobyp_new", 64'(rd_data_b[31:0]), 64'd9);
    check("x4_nobyp_busy_clr", 64'(rd_busy_b[1]), 64'h0);
    tick();

    // Randomized traffic, biased toward a few registers to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      wr_ena     = 1'($urandom % 2);
      wr_addr    = ($urandom % 4 == 0) ? 5'($urandom % 4) : 5'($urandom % 32);
      wr_data    = $urandom;
      claim_ena  = 1'($urandom % 2);
      claim_addr = ($urandom % 3 == 0) ? wr_addr : 5'($urandom % 8);
      flush      = ($urandom % 16 == 0);
      set_rd(($urandom % 2 == 0) ? wr_addr : 5'($urandom % 32),
             ($urandom % 3 == 0) ? claim_addr : 5'($urandom % 8),
             5'($urandom % 32));
      settle();
      tick();
    end
    sweep();

    // Asynchronous reset after x5 is written and claimed.
    wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    claim_ena = 1'b1; claim_addr = 5'd5;
    tick();
    idle();
    set_rd(5'd5, 5'd5, 5'd5);
    settle();
    check("x5_before_rst", 64'(rd_data_a[31:0]), 64'hDEAD_BEEF);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("rst_x5_data", 64'(rd_data_a[31:0]), 64'h0);
    check("rst_busy_vec_a", 64'(busy_vec_a), 64'h0);
    check("rst_busy_vec_b", 64'(busy_vec_b), 64'h0);
    wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_0001;
    claim_ena = 1'b1; claim_addr = 5'd5;
    #1;
    check_outputs();
    tick();
    idle();
    rst_n = 1'b1;
    settle();
    check("rst_no_partial", 64'(rd_data_b[31:0]), 64'h0);
    tick();
    sweep();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised RISC-V integer register file for the pipelined core. It has a configurable number of read ports, optional same-cycle write-to-read bypass, asynchronous clear of all state, and a per-register busy scoreboard that tracks in-flight writebacks for hazard detection. It sits between decode (reads and claims) and writeback (writes and releases). It replaces the fixed two-port, reset-less register file.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers, power of two, ≥ 2; register 0 is hardwired zero.
- NREAD, 2, number of independent read ports, 1–4.
- BYPASS, 1, 1 = a write in the same cycle is forwarded to matching reads; 0 = no forwarding.
- AW, $clog2(NREGS), address width (derived, not overridden).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset; clears all registers and busy bits.
- wr_ena  in  1  writeback enable.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback value.
- rd_addr  in  NREAD*AW  packed read addresses, port k at [k*AW +: AW].
- rd_data  out  NREAD*XLEN  packed read data, port k at [k*XLEN +: XLEN].
- rd_busy  out  NREAD  port k's register has an outstanding claim not satisfied this cycle.
- claim_ena  in  1  decode marks a destination as pending.
- claim_addr  in  AW  destination being claimed.
- flush  in  1  synchronous clear of all busy bits (pipeline flush); data untouched.
- busy_vec  out  NREGS  current scoreboard state, bit 0 always 0.

## Operation
- Storage is registers x1..x(NREGS-1), XLEN bits each, with no RAM inference. Reads of x0 return 0.
- Write: on the edge, if wr_ena && wr_addr != 0, the register at wr_addr takes wr_data. Writes to x0 are dropped.
- Release: the same write also clears busy[wr_addr].
- Claim: on the edge, if claim_ena && claim_addr != 0, busy[claim_addr] is set. Claims of x0 are ignored.
- Same register claimed and written in one cycle: the claim wins and busy stays 1, because the new instruction's claim is younger. The data is still written.
- flush: all busy bits go to 0 on the edge. flush overrides a simultaneous claim. A simultaneous write still updates data.
- Read data is combinational from rd_addr:
  - If BYPASS=1, wr_ena, wr_addr == rd_addr[k] and rd_addr[k] != 0, then rd_data[k] = wr_data.
  - Otherwise rd_data[k] is the stored value.
- rd_busy[k] = busy[rd_addr[k]], with one exception: with BYPASS=1, a matching write this cycle forces rd_busy[k] = 0.
- Ports are fully independent; any number of ports may read the same address.

## Timing
- Reset (rst_n low, asynchronous):
  - All registers are 0 and all busy bits are 0.
  - rd_data reads 0 and rd_busy is 0 for every address.
  - busy_vec = 0.
  - Release is synchronous to clk via the top-level reset synchroniser.
- Reset asserted mid-write or mid-claim: the reset wins and no partial update survives.
- Write-to-read latency:
  - 0 cycles with BYPASS=1.
  - 1 cycle with BYPASS=0: the value is visible after the writing edge.
- Claim-to-busy latency: 1 cycle. rd_busy is not asserted in the claim cycle itself; decode handles that case.
- busy_vec is registered state only, with no bypass.
- Combinational paths are rd_addr → rd_data/rd_busy and wr_* → rd_data/rd_busy (BYPASS=1). There is no combinational path from claim_* or flush.

## Structure
- Package regfile_pkg holds:
  - XLEN_DEFAULT = 32 and NREGS_DEFAULT = 32.
  - The ZERO_REG = 0 constant.
  - A typedef for the register address (logic [4:0]) used by decode and writeback.
- Sub-module regfile_entry: one XLEN data flop plus its busy flop, with async active-low clear. It takes wr_hit, claim_hit and flush. Instantiate it in a generate loop for indices 1..NREGS-1.
- Read muxing is done in a per-port generate loop indexing a packed array of entry outputs. Do not use an unpacked memory array.

## Test plan
- Reset: drive rst_n low mid-cycle after x5 = 32'hDEADBEEF and claim x5 → rd_data for x5 = 0 and busy_vec = 0 immediately, without waiting for a clock edge.
- Write/read with NREAD=3 and BYPASS=1: write x7 = 32'h1234_5678 while all three ports read x7 → all ports show the value in the same cycle, and it persists after wr_ena drops.
- Zero register: write x0 = 32'hFFFF_FFFF and claim x0 → reads of x0 return 0, busy_vec[0] = 0, and no other register changes.
- Scoreboard: claim x10 → next cycle rd_busy = 1 for x10 and busy_vec[10] = 1. Write x10 = 42 → rd_busy = 0 in the write cycle and busy_vec[10] = 0 after the edge.
- Simultaneous events:
  - Claim and write x12 in the same cycle → x12 data updated, busy_vec[12] = 1.
  - flush together with a claim of x3 → busy_vec = 0.
- BYPASS=0 build: write x4 = 9 and read x4 in the same cycle → old value returned, then 9 on the next cycle; rd_busy stays 1 until after the edge.
